// File: rtl/bch_31_pkg.sv
// Shared constants, types and GF(2^5) arithmetic for the BCH(31,21) t=2 decoder.
package bch_31_pkg;

  localparam int unsigned N = 31;
  localparam int unsigned K = 21;
  localparam int unsigned T = 2;
  localparam logic [5:0] GF_POLY = 6'b100101;

  typedef logic [4:0] gf32_t;

  typedef enum logic [2:0] {
    StIdle,
    StSynd,
    StSolve,
    StChien,
    StDone
  } state_t;

  localparam gf32_t ALPHA      = 5'd2;
  localparam gf32_t ALPHA3     = 5'd8;
  localparam gf32_t ALPHA_INV  = 5'd18;  // alpha^30
  localparam gf32_t ALPHA_INV2 = 5'd9;   // alpha^29

  function automatic gf32_t gf_mul(input gf32_t a, input gf32_t b);
    gf32_t res;
    gf32_t sh;
    res = '0;
    sh  = a;
    for (int i = 0; i < 5; i++) begin
      if (b[i]) res = res ^ sh;
      sh = sh[4] ? ({sh[3:0], 1'b0} ^ GF_POLY[4:0]) : {sh[3:0], 1'b0};
    end
    return res;
  endfunction

  function automatic gf32_t gf_inv(input gf32_t a);
    gf32_t res;
    case (a)
      5'd1:  res = 5'd1;
      5'd2:  res = 5'd18;
      5'd3:  res = 5'd28;
      5'd4:  res = 5'd9;
      5'd5:  res = 5'd23;
      5'd6:  res = 5'd14;
      5'd7:  res = 5'd12;
      5'd8:  res = 5'd22;
      5'd9:  res = 5'd4;
      5'd10: res = 5'd25;
      5'd11: res = 5'd16;
      5'd12: res = 5'd7;
      5'd13: res = 5'd15;
      5'd14: res = 5'd6;
      5'd15: res = 5'd13;
      5'd16: res = 5'd11;
      5'd17: res = 5'd24;
      5'd18: res = 5'd2;
      5'd19: res = 5'd29;
      5'd20: res = 5'd30;
      5'd21: res = 5'd26;
      5'd22: res = 5'd8;
      5'd23: res = 5'd5;
      5'd24: res = 5'd17;
      5'd25: res = 5'd10;
      5'd26: res = 5'd21;
      5'd27: res = 5'd31;
      5'd28: res = 5'd3;
      5'd29: res = 5'd19;
      5'd30: res = 5'd20;
      5'd31: res = 5'd27;
      default: res = 5'd0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/bch_31_chien.sv
// Serial Chien search cell: evaluates 1 + t1 + t2 at alpha^-k, stepping k once per cycle.
module bch_31_chien
  import bch_31_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  i_load,
  input  gf32_t i_sigma1,
  input  gf32_t i_sigma2,
  input  logic  i_step,
  output logic  o_hit
);

  gf32_t r_t1;
  gf32_t r_t2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_t1 <= '0;
      r_t2 <= '0;
    end else if (i_load) begin
      r_t1 <= i_sigma1;
      r_t2 <= i_sigma2;
    end else if (i_step) begin
      r_t1 <= gf_mul(r_t1, ALPHA_INV);
      r_t2 <= gf_mul(r_t2, ALPHA_INV2);
    end
  end

  assign o_hit = ((5'd1 ^ r_t1 ^ r_t2) == 5'd0);

endmodule

// File: rtl/bch_31_decoder.sv
// BCH(31,21) t=2 hard-decision decoder: serial syndromes, Peterson solve, serial Chien search.
module bch_31_decoder
  import bch_31_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [30:0] rx_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [20:0] msg_out,
  output logic [1:0]  err_cnt,
  output logic        uncorr
);

  localparam logic [4:0] LAST_IDX = 5'(N - 1);
  localparam logic [1:0] ROOT_MAX = 2'(T + 1);

  state_t         r_state, w_state_next;
  logic [30:0]    r_rx, r_word;
  gf32_t          r_s1, r_s3;
  logic [4:0]     r_idx;
  logic [1:0]     r_deg, r_roots;
  logic           r_flag;
  logic [K-1:0]   r_msg;
  logic [1:0]     r_cnt;
  logic           r_unc;

  logic           w_load, w_step, w_hit, w_bit, w_flag;
  gf32_t          w_s1_next, w_s3_next, w_s1_sq, w_s1_cube, w_sig1, w_sig2;
  logic [1:0]     w_deg, w_roots;
  logic [30:0]    w_word;

  assign w_bit     = r_rx[r_idx];
  assign w_s1_next = gf_mul(r_s1, ALPHA) ^ {4'b0, w_bit};
  assign w_s3_next = gf_mul(r_s3, ALPHA3) ^ {4'b0, w_bit};
  assign w_s1_sq   = gf_mul(r_s1, r_s1);
  assign w_s1_cube = gf_mul(w_s1_sq, r_s1);

  // Peterson closed form; S1=0 with S3!=0 has no valid locator of degree <= 2.
  always_comb begin
    w_sig1 = '0;
    w_sig2 = '0;
    w_deg  = 2'd0;
    w_flag = 1'b0;
    if (r_s1 != '0) begin
      w_sig1 = r_s1;
      if (r_s3 == w_s1_cube) begin
        w_deg = 2'd1;
      end else begin
        w_sig2 = gf_mul(r_s3, gf_inv(r_s1)) ^ w_s1_sq;
        w_deg  = 2'd2;
      end
    end else if (r_s3 != '0) begin
      w_flag = 1'b1;
    end
  end

  bch_31_chien u_chien (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_sigma1 (w_sig1),
    .i_sigma2 (w_sig2),
    .i_step   (w_step),
    .o_hit    (w_hit)
  );

  // A root at alpha^-k locates an error at bit k.
  assign w_word  = r_word ^ (w_hit ? (31'd1 << r_idx) : 31'd0);
  assign w_roots = (w_hit && (r_roots != ROOT_MAX)) ? r_roots + 2'd1 : r_roots;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    unique case (r_state)
      StIdle:  if (in_valid) w_state_next = StSynd;
      StSynd:  if (r_idx == 5'd0) w_state_next = StSolve;
      StSolve: begin
        w_load       = 1'b1;
        w_state_next = StChien;
      end
      StChien: begin
        w_step = 1'b1;
        if (r_idx == LAST_IDX) w_state_next = StDone;
      end
      StDone:  if (out_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx    <= '0;
      r_word  <= '0;
      r_s1    <= '0;
      r_s3    <= '0;
      r_idx   <= '0;
      r_deg   <= '0;
      r_roots <= '0;
      r_flag  <= 1'b0;
      r_msg   <= '0;
      r_cnt   <= '0;
      r_unc   <= 1'b0;
    end else begin
      case (r_state)
        StIdle: if (in_valid) begin
          r_rx   <= rx_word;
          r_word <= rx_word;
          r_s1   <= '0;
          r_s3   <= '0;
          r_idx  <= LAST_IDX;
        end
        StSynd: begin
          r_s1  <= w_s1_next;
          r_s3  <= w_s3_next;
          r_idx <= r_idx - 5'd1;
        end
        StSolve: begin
          r_deg   <= w_deg;
          r_flag  <= w_flag;
          r_roots <= '0;
          r_idx   <= '0;
        end
        StChien: begin
          r_word  <= w_word;
          r_roots <= w_roots;
          r_idx   <= r_idx + 5'd1;
          if (r_idx == LAST_IDX) begin
            if ((w_roots != r_deg) || r_flag) begin
              r_unc <= 1'b1;
              r_cnt <= 2'd0;
              r_msg <= r_rx[30:10];
            end else begin
              r_unc <= 1'b0;
              r_cnt <= r_deg;
              r_msg <= w_word[30:10];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == StIdle);
  assign out_valid = (r_state == StDone);
  assign msg_out   = r_msg;
  assign err_cnt   = r_cnt;
  assign uncorr    = r_unc;

endmodule
